// File: rtl/wb_slave_ram_pipe_if.sv
// Wishbone B4 bus bundle between one master and the RAM slave.
// Master drives the request fields; slave returns data and terminations.
interface wb_slave_ram_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack;
  logic                    err;
  logic                    stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_i,
    input  dat_o, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_i,
    output dat_o, ack, err, stall
  );
endinterface

// File: rtl/wb_slave_ram_pipe.sv
// Wishbone B4 byte-writable RAM slave, classic or pipelined, with optional
// wait states and err termination for addresses beyond MEM_DEPTH.
module wb_slave_ram_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 65536,
  parameter bit PIPELINED   = 1'b1,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  wb_slave_ram_pipe_if.slave  wb,
  output logic [1:0]          dbg_state
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_flag_q, err_flag_d;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  req_valid;
  logic                  accept;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic [IDX_WIDTH-1:0]  mem_idx;

  // Handshake: a request (cyc & stb) is taken on a rising edge when the FSM
  // can accept and stall is low; each taken request ends in exactly one
  // ack or err pulse unless cyc drops first, which cancels it silently.
  assign req_valid = wb.cyc & wb.stb;
  assign in_range  = ({1'b0, wb.adr} < DEPTH_LIMIT);
  assign mem_idx   = wb.adr[IDX_WIDTH-1:0];
  assign wr_en     = rst & accept & wb.we & in_range;
  assign rd_en     = rst & accept & ~wb.we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: accept = req_valid;
      ST_WAIT: begin
        if (!wb.cyc) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        accept  = req_valid & PIPELINED;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A pipelined RESP hands over to the next request in the same cycle.
    if (accept) begin
      err_flag_d = ~in_range;
      if (WAIT_STATES == 0) begin
        state_d = ST_RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  // RAM array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wb.sel[i]) mem[mem_idx][8*i +: 8] <= wb.dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dat_q <= '0;
    end else if (accept) begin
      dat_q <= (rd_en && in_range) ? mem[mem_idx] : '0;
    end
  end

  assign wb.dat_o  = dat_q;
  assign wb.ack    = (state_q == ST_RESP) & wb.cyc & ~err_flag_q;
  assign wb.err    = (state_q == ST_RESP) & wb.cyc & err_flag_q;
  assign wb.stall  = PIPELINED & (state_q == ST_WAIT) & wb.cyc;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_slave_ram_pipe.sv
// Directed bench for wb_slave_ram_pipe: four instances cover pipelined
// zero-wait, pipelined with wait states, classic mode and cycle abort.
module tb_wb_slave_ram_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  logic [1:0] dbg0, dbg1, dbg2, dbg3;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_slave_ram_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if0 ();
  wb_slave_ram_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if1 ();
  wb_slave_ram_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if2 ();
  wb_slave_ram_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if3 ();

  wb_slave_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024),
                      .PIPELINED(1'b1), .WAIT_STATES(0))
    u_dut0 (.clk(clk), .rst(rst), .wb(if0.slave), .dbg_state(dbg0));
  wb_slave_ram_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_DEPTH(1024),
                      .PIPELINED(1'b1), .WAIT_STATES(3))
    u_dut1 (.clk(clk), .rst(rst), .wb(if1.slave), .dbg_state(dbg1));
  wb_slave_ram_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_DEPTH(1024),
                      .PIPELINED(1'b0), .WAIT_STATES(0))
    u_dut2 (.clk(clk), .rst(rst), .wb(if2.slave), .dbg_state(dbg2));
  wb_slave_ram_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_DEPTH(1024),
                      .PIPELINED(1'b1), .WAIT_STATES(2))
    u_dut3 (.clk(clk), .rst(rst), .wb(if3.slave), .dbg_state(dbg3));

  typedef struct {
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [15:0] adr;
    logic [31:0] dat;
    logic        e_ack;
    logic        e_err;
    logic        chk_dat;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic s, input logic w,
                     input logic [3:0] sel, input logic [15:0] adr, input logic [31:0] dat,
                     input logic ea, input logic ee, input logic cd, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.sel = sel; v.adr = adr; v.dat = dat;
    v.e_ack = ea; v.e_err = ee; v.chk_dat = cd; v.e_dat = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_all();
    if0.cyc = 0; if0.stb = 0; if0.we = 0; if0.sel = '0; if0.adr = '0; if0.dat_i = '0;
    if1.cyc = 0; if1.stb = 0; if1.we = 0; if1.sel = '0; if1.adr = '0; if1.dat_i = '0;
    if2.cyc = 0; if2.stb = 0; if2.we = 0; if2.sel = '0; if2.adr = '0; if2.dat_i = '0;
    if3.cyc = 0; if3.stb = 0; if3.we = 0; if3.sel = '0; if3.adr = '0; if3.dat_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- table: pipelined, zero wait, 32-bit ----------------
    // reset held with a live request
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 4'hF, 16'd0, 32'd0, 0, 0, 1, 32'd0);
    // write burst: first ack one cycle after acceptance
    for (int i = 0; i < 8; i++)
      add(1, 1, 1, 1, 4'hF, 16'(i), 32'hA000 + 32'(i), (i > 0), 0, 0, 32'd0);
    // read burst: each row sees the ack of the previous request
    for (int i = 0; i < 8; i++)
      add(1, 1, 1, 0, 4'hF, 16'(i), 32'd0, 1, 0, (i > 0), 32'hA000 + 32'(i) - 32'd1);
    add(1, 1, 0, 0, 4'hF, 16'd0, 32'd0, 1, 0, 1, 32'h0000A007);
    // byte lanes
    add(1, 1, 1, 1, 4'hF, 16'd20, 32'h11223344, 0, 0, 0, 32'd0);
    add(1, 1, 1, 1, 4'h5, 16'd20, 32'hAABBCCDD, 1, 0, 0, 32'd0);
    add(1, 1, 1, 0, 4'h0, 16'd20, 32'd0,        1, 0, 0, 32'd0);
    add(1, 1, 0, 0, 4'h0, 16'd0,  32'd0,        1, 0, 1, 32'h11BB33DD);
    // out-of-range read
    add(1, 1, 1, 0, 4'hF, 16'd1024, 32'd0, 0, 0, 0, 32'd0);
    add(1, 1, 0, 0, 4'hF, 16'd0,    32'd0, 0, 1, 1, 32'd0);
    // sel=0 write changes nothing but still acks
    add(1, 1, 1, 1, 4'h0, 16'd20, 32'hFFFFFFFF, 0, 0, 0, 32'd0);
    add(1, 1, 1, 0, 4'hF, 16'd20, 32'd0,        1, 0, 0, 32'd0);
    add(1, 1, 0, 0, 4'hF, 16'd0,  32'd0,        1, 0, 1, 32'h11BB33DD);
    add(1, 0, 0, 0, 4'h0, 16'd0,  32'd0,        0, 0, 0, 32'd0);
    // out-of-range write at top of address space
    add(1, 1, 1, 1, 4'hF, 16'hFFFF, 32'h12345678, 0, 0, 0, 32'd0);
    add(1, 1, 0, 0, 4'hF, 16'd0,    32'd0,        0, 1, 1, 32'd0);
    add(1, 0, 0, 0, 4'h0, 16'd0,    32'd0,        0, 0, 0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      if0.cyc = vecs[i].cyc; if0.stb = vecs[i].stb; if0.we = vecs[i].we;
      if0.sel = vecs[i].sel; if0.adr = vecs[i].adr; if0.dat_i = vecs[i].dat;
      @(negedge clk);
      check($sformatf("vec%0d ack", i),   32'(if0.ack),   32'(vecs[i].e_ack));
      check($sformatf("vec%0d err", i),   32'(if0.err),   32'(vecs[i].e_err));
      check($sformatf("vec%0d stall", i), 32'(if0.stall), 32'd0);
      if (vecs[i].chk_dat) check($sformatf("vec%0d dat", i), if0.dat_o, vecs[i].e_dat);
    end

    // ---------------- pipelined, 3 wait states ----------------
    @(posedge clk); #1;
    if1.cyc = 1; if1.stb = 1; if1.we = 1; if1.sel = 2'b11; if1.adr = 16'd5; if1.dat_i = 16'h1234;
    @(negedge clk);
    check("ws3 idle stall", 32'(if1.stall), 32'd0);
    @(posedge clk); #1;
    if1.we = 0; if1.dat_i = 16'h0;
    exp_q.push_back(32'h1234);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("ws3 c%0d stall", c), 32'(if1.stall), 32'((c != 4) && (c != 8)));
      check($sformatf("ws3 c%0d ack", c),   32'(if1.ack),   32'((c == 4) || (c == 8)));
      check($sformatf("ws3 c%0d err", c),   32'(if1.err),   32'd0);
      if (c == 8) begin
        if (exp_q.size() == 0) check("ws3 scoreboard empty", 32'd1, 32'd0);
        else check("ws3 read dat", 32'(if1.dat_o), exp_q.pop_front());
      end
      @(posedge clk); #1;
      if (c == 4) if1.stb = 0;
      if (c == 8) if1.cyc = 0;
    end

    // ---------------- classic, zero wait ----------------
    for (int c = 0; c < 6; c++) exp_q.push_back(32'(c % 2));
    if2.cyc = 1; if2.stb = 1; if2.we = 0; if2.sel = 2'b11; if2.adr = 16'd3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("classic c%0d ack", c), 32'(if2.ack), exp_q.pop_front());
      check($sformatf("classic c%0d stall", c), 32'(if2.stall), 32'd0);
      @(posedge clk); #1;
    end
    if2.adr = 16'd1024;
    @(negedge clk);
    check("classic oor pre ack", 32'(if2.ack), 32'd0);
    check("classic oor pre err", 32'(if2.err), 32'd0);
    @(posedge clk); #1;
    if2.stb = 0;
    @(negedge clk);
    check("classic oor err", 32'(if2.err), 32'd1);
    check("classic oor ack", 32'(if2.ack), 32'd0);
    check("classic oor dat", 32'(if2.dat_o), 32'd0);
    @(posedge clk); #1;
    if2.cyc = 0;

    // ---------------- abort with 2 wait states ----------------
    if3.cyc = 1; if3.stb = 1; if3.we = 1; if3.sel = 2'b11; if3.adr = 16'd9; if3.dat_i = 16'h5A5A;
    @(negedge clk);
    check("abort idle ack", 32'(if3.ack), 32'd0);
    @(posedge clk); #1;
    if3.cyc = 0; if3.stb = 0; if3.we = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("abort c%0d ack", c),   32'(if3.ack),   32'd0);
      check($sformatf("abort c%0d err", c),   32'(if3.err),   32'd0);
      check($sformatf("abort c%0d stall", c), 32'(if3.stall), 32'd0);
    end
    @(posedge clk); #1;
    if3.cyc = 1; if3.stb = 1; if3.adr = 16'd9;
    @(negedge clk);
    check("abort read idle ack", 32'(if3.ack), 32'd0);
    @(posedge clk); #1;
    if3.stb = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("abort rd c%0d ack", c),   32'(if3.ack),   32'(c == 3));
      check($sformatf("abort rd c%0d stall", c), 32'(if3.stall), 32'(c != 3));
      if (c == 3) check("abort rd dat", 32'(if3.dat_o), 32'h5A5A);
    end
    @(posedge clk); #1;
    if3.cyc = 0;
    @(negedge clk);
    check("abort final ack", 32'(if3.ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
